// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the MDUOp op-code constants, the FSM state type and the op-class
// decode helpers used by iter_mdu.
// The accumulate ops (madd/maddu/msub/msubu) are only recognised when the
// MDU_MADD_EN macro is defined. Otherwise they decode as "none".
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd9;
  localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd10;
  localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd11;
  localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  // Ops that start an iteration (multiply, divide and, when built in,
  // the multiply-accumulate family).
  function automatic logic is_md_op(input logic [MDU_OP_W-1:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_md_op = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: is_md_op = 1'b1;
`endif
      default: is_md_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    is_div_op = (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops whose operands are two's-complement and need magnitude/sign split.
  function automatic logic is_signed_op(input logic [MDU_OP_W-1:0] op);
    is_signed_op = (op == MDU_MULT) || (op == MDU_DIV) ||
                   (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-divide step.
// Ports:
//   rem      in  WIDTH  partial remainder (always < dvsr on entry)
//   quo      in  WIDTH  dividend bits still to shift in, quotient bits in LSBs
//   dvsr     in  WIDTH  divisor magnitude
//   rem_next out WIDTH  remainder after this step
//   quo_next out WIDTH  shifted dividend/quotient with the new quotient bit
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr};

  // A set MSB on the trial difference is a borrow: the divisor did not fit,
  // so the shifted remainder is restored and the quotient bit is 0.
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/iter_mdu.sv
// iter_mdu: iterative multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, WIDTH steps each, followed
// by one sign-fix cycle. busy is high for WIDTH+1 cycles per operation.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu.
// Ports:
//   clk      in  1      rising-edge clock
//   reset_n  in  1      asynchronous active-low reset
//   D1       in  WIDTH  rs: dividend / multiplicand / mthi-mtlo source
//   D2       in  WIDTH  rt: divisor / multiplier
//   MDUOp    in  OP_W   operation code (see mdu_pkg)
//   Req      in  1      exception request, blocks issue this cycle
//   start    out 1      combinational issue strobe
//   busy     out 1      iteration in progress
//   done     out 1      one-cycle pulse when hi/lo take the result
//   hi, lo   out WIDTH  HI/LO registers
//   out      out WIDTH  hi for mfhi, lo for mflo, else 0
module iter_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [OP_W-1:0]  MDUOp,
  input  logic             Req,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] out
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;      // mul: {partial product, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0]     opb;      // mul: multiplicand magnitude; div: divisor magnitude
  logic [MDU_OP_W-1:0]  op_r;
  logic                 neg_res;  // product / quotient sign
  logic                 neg_rem;  // remainder sign (dividend sign)
  logic                 dvz;

  // Op codes wider than the package encoding are treated as "none".
  logic [MDU_OP_W-1:0]  op;
  always_comb begin
    op = MDU_NONE;
    if ((MDUOp >> MDU_OP_W) == '0) op = MDUOp[MDU_OP_W-1:0];
  end

  logic             can_issue;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign can_issue = !Req && !busy;
  assign start     = can_issue && is_md_op(op);

  assign a_neg = is_signed_op(op) && D1[WIDTH-1];
  assign b_neg = is_signed_op(op) && D2[WIDTH-1];
  assign a_mag = a_neg ? -D1 : D1;
  assign b_mag = b_neg ? -D2 : D2;

  always_comb begin
    out = '0;
    if (op == MDU_MFHI) out = hi;
    if (op == MDU_MFLO) out = lo;
  end

  // Multiply step: conditional add into the upper half, then shift right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  logic [WIDTH-1:0] rem_next, quo_next;
  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .quo      (acc[WIDTH-1:0]),
    .dvsr     (opb),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Sign correction applied in FIX. MIN_INT / -1 needs no special case: the
  // magnitude quotient 2^(WIDTH-1) negates back onto itself.
  logic signed [2*WIDTH-1:0] prod_fix;
  logic signed [WIDTH-1:0]   quo_fix, rem_fix;
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      op_r    <= MDU_NONE;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dvz     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r    <= op;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dvz     <= (D2 == '0);
            cnt     <= '0;
            busy    <= 1'b1;
            if (is_div_op(op)) begin
              acc   <= {{WIDTH{1'b0}}, a_mag};
              opb   <= b_mag;
              state <= ST_DIV;
            end else begin
              acc   <= {{WIDTH{1'b0}}, b_mag};
              opb   <= a_mag;
              state <= ST_MUL;
            end
          end else if (can_issue && op == MDU_MTHI) begin
            hi <= D1;
          end else if (can_issue && op == MDU_MTLO) begin
            lo <= D1;
          end
        end
        ST_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_DIV: begin
          acc <= {rem_next, quo_next};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          case (op_r)
            MDU_DIV, MDU_DIVU: begin
              if (!dvz) begin
                hi <= rem_fix;
                lo <= quo_fix;
              end
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: {hi, lo} <= {hi, lo} + prod_fix;
            MDU_MSUB, MDU_MSUBU: {hi, lo} <= {hi, lo} - prod_fix;
`endif
            default: {hi, lo} <= prod_fix;
          endcase
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/iter_mdu.md
# iter_mdu

Parametrised, iterative multiply/divide unit with HI/LO registers. It is the next-generation replacement for the single-shot MDU in the pipeline's EX stage. Radix-2 shift-add multiply and restoring divide take a fixed, width-proportional number of cycles. The hazard unit stalls on `start | busy`, the exception path suppresses issue through `Req`, and MADD/MSUB accumulate ops are available as a build option.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI/LO are each WIDTH bits; must be ≥ 4 and even.
- `OP_W`, default 4: width of `MDUOp`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `D1`  in  WIDTH  rs operand; dividend / multiplicand / mthi-mtlo source.
- `D2`  in  WIDTH  rt operand; divisor / multiplier.
- `MDUOp`  in  OP_W  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu.
- `Req`  in  1  exception/interrupt request; suppresses issue this cycle.
- `start`  out  1  combinational: `!Req & !busy &` (MDUOp is mult/div/madd class).
- `busy`  out  1  registered: iteration in progress.
- `done`  out  1  registered one-cycle pulse on the cycle HI/LO take the result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `out`  out  WIDTH  combinational: hi for mfhi, lo for mflo, else 0.

## Operation
Reset: while `reset_n` is 0, `busy`, `done`, `hi`, `lo`, the iteration counter and all datapath registers are 0 and the FSM is IDLE.

FSM states:
- **IDLE.** On `start`, latch the operand magnitudes, signs and the op, then go to MUL or DIV. mthi/mtlo write `hi`/`lo` from D1 in one edge, only when `!Req & !busy`. Any op is ignored while `busy` or `Req`.
- **MUL.** One shift-add step per cycle over the 2·WIDTH product of magnitudes. After WIDTH steps, go to FIX.
- **DIV.** One restoring subtract-shift step per cycle. After WIDTH steps, go to FIX.
- **FIX.** Apply sign correction, then the accumulate if enabled. Write hi/lo, pulse `done`, clear `busy`, return to IDLE.

Arithmetic rules:
- **Signed multiply.** Sign of the product is the XOR of the operand signs.
- **Signed divide.** Quotient truncates toward zero; the remainder takes the dividend's sign.
- **MIN_INT / −1.** Quotient is MIN_INT and remainder is 0 (wraps, no trap).
- **Divide by zero (D2 == 0).** Runs the full latency; `hi`/`lo` are left unchanged; `done` still pulses.
- **Operand capture.** D1/D2 are sampled only at the issue edge; later changes have no effect.

Other rules:
- `Req` never aborts an in-flight operation; it only blocks issue in the cycle it is high.
- An asynchronous reset mid-operation discards the result and leaves hi = lo = 0.

## Timing
- Issue edge T0, when `start` = 1: `busy` = 1 from T0 through T0+WIDTH+1.
- FIX edge is T0+WIDTH+1. There `hi`/`lo` update, `done` = 1 for one cycle, and `busy` falls.
- Total `busy`-high cycles: WIDTH+1 (33 for WIDTH=32), identical for mult and div.
- A new op may issue on the cycle `busy` is 0, i.e. the cycle `done` is high.
- `out` reflects the `hi`/`lo` register values (no bypass of the pending result).
- mthi/mtlo take effect at the next edge.

## Configuration
- `MDU_MADD_EN` defined: ops 9–12 are legal.
  - FIX adds (madd/maddu) or subtracts (msub/msubu) the corrected 2·WIDTH product to or from {hi,lo}, modulo 2^(2·WIDTH).
  - Same latency as mult.
- `MDU_MADD_EN` undefined: ops 9–12 decode as "none". `start` stays 0 for them and hi/lo are untouched.

## Structure
- Shared package `mdu_pkg` holds:
  - the OP_W op-code localparams (`MDU_NONE` … `MDU_MSUBU`);
  - the FSM state enum (IDLE, MUL, DIV, FIX);
  - helper function `is_md_op`.
- Sub-module `mdu_divstep` holds the combinational restoring-divide step (remainder/quotient shift, trial subtract, select), instantiated once.
- The multiply step stays inline.

## Test plan
- **Signed multiply:** reset, then mult D1=−3 (0xFFFFFFFD), D2=7 → `busy` for 33 cycles; `done` pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB; mflo drives `out`=0xFFFFFFEB.
- **Signed divide:** div D1=−7, D2=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). divu 0x80000000/3 → lo=0x2AAAAAAA, hi=2.
- **Divide by zero:** mthi 0x11, mtlo 0x22, then div D1=5, D2=0 → `done` after 33 cycles; hi=0x11, lo=0x22.
- **Issue gating:** mult with `Req`=1 → `start`=0, `busy` stays 0, hi/lo unchanged. Mid-operation mthi → ignored. `Req` pulse mid-operation → result still written.
- **Reset mid-operation:** `reset_n` low at cycle 10 of a multu → `busy`, `done`, hi, lo all 0 immediately; next mult completes normally.
- **Accumulate (`MDU_MADD_EN`):** hi=0, lo=5, then madd D1=2, D2=3 → lo=11. msubu D1=1, D2=12 → {hi,lo}=0xFFFFFFFF_FFFFFFFF. Without the macro, op 9 → `start`=0 and no change.
